// File: rtl/mac_dot_unit.sv
// mac_dot_unit -- streaming signed multiply-accumulate dot-product engine.
//
// Operand pairs arrive on a valid/ready input channel. Each vector of `len`
// elements (0 counts as 1) is multiplied pairwise and accumulated, adding or
// subtracting each product under the per-element `sub` flag. The finished dot
// product is presented on a valid/ready output channel and held stable until
// it is taken.
//
// Datapath: stage 1 registers the full-width signed product, and stage 2
// updates the accumulator. The first element of a vector loads the
// accumulator directly, so no clear cycle is needed between vectors.
//
// Build option: define MAC_SAT_EN to clamp the accumulator on signed
// overflow. Without it the accumulator wraps modulo 2^WIDTH_P. In both
// builds `ovf` reports that an overflow occurred in the vector.
module mac_dot_unit #(
  parameter int WIDTH_A = 16,  // signed A operand width, 2..25
  parameter int WIDTH_B = 16,  // signed B operand width, 2..18
  parameter int WIDTH_P = 32,  // accumulator / result width, >= WIDTH_A+WIDTH_B, <= 48
  parameter int LEN_W   = 8    // vector-length field width
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_A-1:0] A,
  input  logic signed [WIDTH_B-1:0] B,
  input  logic                      sub,
  input  logic        [LEN_W-1:0]   len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_P-1:0] p_out,
  output logic                      ovf,
  output logic                      busy
);

  localparam int WIDTH_M = WIDTH_A + WIDTH_B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Control state and registered handshake outputs
  state_t                    r_state;
  logic [LEN_W-1:0]          r_count;
  logic                      r_in_ready;
  logic                      r_busy;
  logic                      r_out_valid;
  logic signed [WIDTH_P-1:0] r_p_out;
  logic                      r_ovf_out;

  // Stage 1: registered product and its per-element tags
  logic                      r_s1_valid;
  logic                      r_s1_first;
  logic                      r_s1_sub;
  logic signed [WIDTH_P-1:0] r_s1_prod;

  // Stage 2: accumulator and the sticky overflow flag of the running vector
  logic signed [WIDTH_P-1:0] r_acc;
  logic                      r_acc_ovf;

  // Combinational helpers
  logic                      w_accept;
  logic                      w_first_beat;
  logic                      w_len_le1;
  logic                      w_last_acc;
  logic signed [WIDTH_M-1:0] w_prod;
  logic signed [WIDTH_P-1:0] w_acc_base;
  logic        [WIDTH_P:0]   w_sum;
  logic                      w_step_ovf;
  logic signed [WIDTH_P-1:0] w_acc_next;

  // in_ready and busy come straight from registers that track the state,
  // so neither depends on in_valid or out_ready in the same cycle.
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign p_out     = r_p_out;
  assign ovf       = r_ovf_out;

  assign w_accept     = in_valid && r_in_ready;
  assign w_first_beat = w_accept && (r_state == S_IDLE);
  // A length of 0 or 1 is a single-element vector.
  assign w_len_le1    = (len <= LEN_W'(1));
  assign w_last_acc   = (r_count == LEN_W'(1));

  // Both operands are widened to the full product width before multiplying.
  // The product is then exact for every operand combination.
  assign w_prod = WIDTH_M'(A) * WIDTH_M'(B);

  // Vector-level control: count accepted elements, drain, present result
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments only. Every
    // always_ff then samples the pre-edge values of the others, whatever
    // order the simulator runs them in.
    if (RST) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_p_out     <= '0;
      r_ovf_out   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (w_len_le1) begin
              r_state    <= S_FLUSH;
              r_count    <= '0;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= S_ACC;
              r_count <= len - LEN_W'(1);
            end
          end
        end
        S_ACC: begin
          if (w_accept) begin
            if (w_last_acc) begin
              r_state    <= S_FLUSH;
              r_count    <= '0;
              r_in_ready <= 1'b0;
            end else begin
              r_count <= r_count - LEN_W'(1);
            end
          end
        end
        S_FLUSH: begin
          // Wait until the last product has passed through stage 2.
          // The accumulator then holds the final dot product.
          if (!r_s1_valid) begin
            r_state     <= S_OUT;
            r_p_out     <= r_acc;
            r_ovf_out   <= r_acc_ovf;
            r_out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (r_out_valid && out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_count     <= '0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the sign-extended product of each accepted beat
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_prod  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= w_first_beat;
        r_s1_sub   <= sub;
        r_s1_prod  <= WIDTH_P'(w_prod);
      end
    end
  end

`ifdef MAC_SAT_EN
  localparam logic signed [WIDTH_P-1:0] ACC_MAX = {1'b0, {(WIDTH_P-1){1'b1}}};
  localparam logic signed [WIDTH_P-1:0] ACC_MIN = {1'b1, {(WIDTH_P-1){1'b0}}};
`endif

  // Stage 2 arithmetic: one guard bit exposes signed overflow of acc +/- prod
  always_comb begin
    // NOTE: every output of this block is assigned on every path before any
    // conditional override. This keeps synthesis from inferring a latch.
    w_acc_base = r_s1_first ? '0 : r_acc;
    if (r_s1_sub) begin
      w_sum = {w_acc_base[WIDTH_P-1], w_acc_base} - {r_s1_prod[WIDTH_P-1], r_s1_prod};
    end else begin
      w_sum = {w_acc_base[WIDTH_P-1], w_acc_base} + {r_s1_prod[WIDTH_P-1], r_s1_prod};
    end
    // The guard bit holds the true sign. Overflow occurred when it differs
    // from the MSB of the WIDTH_P-bit result.
    w_step_ovf = w_sum[WIDTH_P] ^ w_sum[WIDTH_P-1];
    w_acc_next = w_sum[WIDTH_P-1:0];
`ifdef MAC_SAT_EN
    if (w_step_ovf) begin
      w_acc_next = w_sum[WIDTH_P] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  // Stage 2 register: accumulate and collect sticky overflow for the vector
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else if (r_s1_valid) begin
      r_acc     <= w_acc_next;
      // The first element of a vector starts a fresh overflow history.
      r_acc_ovf <= (r_s1_first ? 1'b0 : r_acc_ovf) | w_step_ovf;
    end
  end

endmodule

// File: tb/tb_mac_dot_unit.sv
// Self-checking bench for mac_dot_unit.
//
// Two instances share one stimulus stream and so run in lockstep:
//   dut   : 16x16 -> 32 (default widths)
//   dut_s : 8x8   -> 20 (driven by the low byte of each operand)
// Expected results come from a per-element arithmetic model of the dot
// product. The model works on 64-bit integers and applies the wrap or
// saturate rule for the chosen result width.
module tb_mac_dot_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub_in = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [7:0]  len_in = '0;

  logic        in_ready, out_valid, ovf, busy;
  logic [31:0] p_out;
  logic        in_ready_s, out_valid_s, ovf_s, busy_s;
  logic [19:0] p_out_s;

  int checks = 0;
  int errors = 0;

  int q_a[$];
  int q_b[$];
  bit q_sub[$];

  always #5 clk = ~clk;

  mac_dot_unit #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_P(32), .LEN_W(8)) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .sub(sub_in), .len(len_in),
    .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out),
    .ovf(ovf), .busy(busy)
  );

  mac_dot_unit #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_P(20), .LEN_W(8)) dut_s (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(a_in[7:0]), .B(b_in[7:0]), .sub(sub_in), .len(len_in),
    .out_valid(out_valid_s), .out_ready(out_ready), .p_out(p_out_s),
    .ovf(ovf_s), .busy(busy_s)
  );

  // Interpret the low w bits of v as a two's-complement number
  function automatic longint sext(input longint v, input int w);
    longint m;
    m = longint'(1) <<< w;
    v = v & (m - 1);
    if (v >= (m >>> 1)) v = v - m;
    return v;
  endfunction

  // Reference dot product of the queued vector for the given widths
  function automatic void model(input int wa, input int wb, input int wp,
                                output longint res, output bit ov);
    longint acc, pr, t, lim;
    acc = 0;
    ov  = 1'b0;
    lim = longint'(1) <<< (wp - 1);
    foreach (q_a[i]) begin
      pr = sext(longint'(q_a[i]), wa) * sext(longint'(q_b[i]), wb);
      t  = q_sub[i] ? acc - pr : acc + pr;
      if (t > lim - 1 || t < -lim) begin
        ov = 1'b1;
`ifdef MAC_SAT_EN
        t = (t > 0) ? lim - 1 : -lim;
`else
        t = sext(t, wp);
`endif
      end
      acc = t;
    end
    res = acc;
  endfunction

  task automatic push(input int a, input int b, input bit s);
    q_a.push_back(a);
    q_b.push_back(b);
    q_sub.push_back(s);
  endtask

  // Stream the queued vector, check latency, result, hold under stall and
  // the output handshake, then empty the queues.
  task automatic run_vector(input int len_field, input int gap, input int stall,
                            output logic [31:0] got_p, output logic got_o,
                            output logic [19:0] got_ps);
    int t;
    logic ir1;
    logic [31:0] hold_p;
    logic hold_o;
    longint eb, es;
    bit ob, os;
    model(16, 16, 32, eb, ob);
    model(8, 8, 20, es, os);
    out_ready = (stall == 0);
    foreach (q_a[i]) begin
      if (i > 0) begin
        repeat (gap) begin
          in_valid = 1'b0;
          len_in = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      a_in   = 16'(q_a[i]);
      b_in   = 16'(q_b[i]);
      sub_in = q_sub[i];
      // len matters only on the first beat; later beats carry noise.
      len_in = (i == 0) ? 8'(len_field) : 8'($urandom);
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout element %0d in_ready stayed %b", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    sub_in   = 1'b0;

    t = 0;
    ir1 = 1'bx;
    while (out_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
      if (t == 1) ir1 = in_ready;
    end
    checks++;
    if (t != 2 || ir1 !== 1'b0) begin
      errors++;
      $display("FAIL latency edges %0d in_ready_after_last %b, required 2 and 0", t, ir1);
    end

    got_p  = p_out;
    got_o  = ovf;
    got_ps = p_out_s;
    checks++;
    if (p_out !== 32'(eb) || ovf !== ob) begin
      errors++;
      $display("FAIL result_32 got %0d ovf %b, required %0d ovf %b",
               $signed(p_out), ovf, $signed(32'(eb)), ob);
    end
    checks++;
    if (out_valid_s !== 1'b1 || p_out_s !== 20'(es) || ovf_s !== os) begin
      errors++;
      $display("FAIL result_20 got valid %b %0d ovf %b, required valid 1 %0d ovf %b",
               out_valid_s, $signed(p_out_s), ovf_s, $signed(20'(es)), os);
    end

    hold_p = p_out;
    hold_o = ovf;
    repeat (stall) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || p_out !== hold_p || ovf !== hold_o || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold valid %b p_out %h ovf %b in_ready %b, required 1 %h %b 0",
                 out_valid, p_out, ovf, in_ready, hold_p, hold_o);
      end
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        in_ready_s !== 1'b1 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL handshake valid %b in_ready %b/%b busy %b/%b, required 0 1/1 0/0",
               out_valid, in_ready, in_ready_s, busy, busy_s);
    end
    q_a.delete();
    q_b.delete();
    q_sub.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #20;
    checks++;
    if (out_valid !== 1'b0 || p_out !== 32'd0 || ovf !== 1'b0 || busy !== 1'b0 ||
        out_valid_s !== 1'b0 || p_out_s !== 20'd0 || ovf_s !== 1'b0 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_values valid %b p_out %h ovf %b busy %b, required all zero",
               out_valid, p_out, ovf, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b/%b required 1", in_ready, in_ready_s);
    end
  endtask

  task automatic test_basic();
    logic [31:0] gp; logic go; logic [19:0] gs;
    push(1, 5, 0); push(2, 6, 0); push(3, 7, 0); push(4, 8, 0);
    run_vector(4, 0, 0, gp, go, gs);
    checks++;
    if (gp !== 32'd70 || go !== 1'b0) begin
      errors++;
      $display("FAIL basic_dot got %0d ovf %b required 70 ovf 0", $signed(gp), go);
    end
  endtask

  task automatic test_sub_len0();
    logic [31:0] gp; logic go; logic [19:0] gs;
    push(-3, 4, 0); push(2, 2, 1); push(100, -1, 0);
    run_vector(3, 0, 0, gp, go, gs);
    checks++;
    if (gp !== 32'(-116)) begin
      errors++;
      $display("FAIL sub_mix got %0d required -116", $signed(gp));
    end
    push(7, -9, 0);
    run_vector(0, 0, 0, gp, go, gs);
    checks++;
    if (gp !== 32'(-63)) begin
      errors++;
      $display("FAIL len_zero got %0d required -63", $signed(gp));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] gp; logic go; logic [19:0] gs;
    push(1000, 1000, 0); push(-1000, 3, 0);
    run_vector(2, 3, 5, gp, go, gs);
    checks++;
    if (gp !== 32'd997000) begin
      errors++;
      $display("FAIL gap_stall got %0d required 997000", $signed(gp));
    end
  endtask

  task automatic test_overflow();
    logic [31:0] gp; logic go; logic [19:0] gs;
    logic [31:0] exp_p;
`ifdef MAC_SAT_EN
    exp_p = 32'h7FFF_FFFF;
`else
    // 3 * 32767^2 = 3 * (2^30 - 2^16 + 1), taken modulo 2^32
    exp_p = 32'hBFFD_0003;
`endif
    repeat (3) push(32767, 32767, 0);
    run_vector(3, 0, 0, gp, go, gs);
    checks++;
    if (gp !== exp_p || go !== 1'b1) begin
      errors++;
      $display("FAIL overflow got %h ovf %b required %h ovf 1", gp, go, exp_p);
    end
    push(1, 1, 0);
    run_vector(1, 0, 0, gp, go, gs);
    checks++;
    if (gp !== 32'd1 || go !== 1'b0) begin
      errors++;
      $display("FAIL after_overflow got %0d ovf %b required 1 ovf 0", $signed(gp), go);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] gp; logic go; logic [19:0] gs;
    in_valid = 1'b1; sub_in = 1'b0; len_in = 8'd5;
    a_in = 16'd300; b_in = 16'd200;
    @(posedge clk); #1;
    a_in = 16'd77; b_in = 16'd91;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p_out !== 32'd0 || ovf !== 1'b0 || busy !== 1'b0 ||
        p_out_s !== 20'd0 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid valid %b p_out %h ovf %b busy %b, required all zero",
               out_valid, p_out, ovf, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready %b busy %b required 1 0", in_ready, busy);
    end
    push(3, 3, 0);
    run_vector(1, 0, 0, gp, go, gs);
    checks++;
    if (gp !== 32'd9 || go !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got %0d ovf %b required 9 ovf 0", $signed(gp), go);
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] gp; logic go; logic [19:0] gs;
    int n, lf, gap, stall;
    bit hot;
    push(-128, -128, 0); push(-128, 127, 0);
    run_vector(2, 0, 0, gp, go, gs);
    checks++;
    if (gs !== 20'd128) begin
      errors++;
      $display("FAIL narrow_corner got %0d required 128", $signed(gs));
    end
    for (int v = 0; v < 1000; v++) begin
      hot = ($urandom_range(0, 7) == 0);
      if (hot) n = int'($urandom_range(30, 40));
      else if ($urandom_range(0, 7) == 0) n = int'($urandom_range(7, 20));
      else n = int'($urandom_range(1, 6));
      for (int e = 0; e < n; e++) begin
        if (hot) push(-128, -128, 1'b0);
        else push(int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768,
                  1'($urandom_range(0, 1)));
      end
      lf    = (n == 1 && $urandom_range(0, 1) == 1) ? 0 : n;
      gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_vector(lf, gap, stall, gp, go, gs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub_len0();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
